// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting in front of a registered ALU: accepts one request at a time,
// sequences ISSUE/CAPTURE, owns the architectural NZCV flags and presents the writeback.
module alu_issue_ctrl (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_cmd,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_shift_carry,
  input  logic        req_was_shifted,
  input  logic        req_set_flags,
  input  logic [3:0]  req_rd,
  output logic [4:0]  CTRL_cmd,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        src2shift_carry,
  output logic        was_shifted,
  output logic [3:0]  flags,
  input  logic [31:0] ALU_output,
  input  logic [3:0]  NZCV,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        cmd_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StWb} state_e;

  localparam logic [4:0] CmdMov    = 5'b01101;
  localparam logic [4:0] CmdMaxLeg = 5'b10000;
  localparam logic [4:0] CmdTst    = 5'b01000;
  localparam logic [4:0] CmdCmn    = 5'b01011;

  state_e      state_q, state_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic        shift_carry_q, shift_carry_d;
  logic        was_shifted_q, was_shifted_d;
  logic        set_flags_q, set_flags_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        cmd_err_q, cmd_err_d;
  logic [15:0] op_count_q, op_count_d;

  logic req_legal;
  logic is_compare;

  assign req_legal  = (req_cmd <= CmdMaxLeg);
  // TST/TEQ/CMP/CMN only produce flags, never a register result.
  assign is_compare = (cmd_q >= CmdTst) && (cmd_q <= CmdCmn);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    shift_carry_d = shift_carry_q;
    was_shifted_d = was_shifted_q;
    set_flags_d   = set_flags_q;
    rd_d          = rd_q;
    flags_d       = flags_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    cmd_err_d     = 1'b0;
    op_count_d    = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_legal) begin
          cmd_d         = req_cmd;
          src1_d        = req_src1;
          src2_d        = req_src2;
          shift_carry_d = req_shift_carry;
          was_shifted_d = req_was_shifted;
          set_flags_d   = req_set_flags;
          rd_d          = req_rd;
          state_d       = StIssue;
        end else if (req_valid) begin
          cmd_err_d = 1'b1;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        wb_data_d  = ALU_output;
        wb_rd_d    = rd_q;
        op_count_d = op_count_q + 16'd1;
        if (set_flags_q || is_compare) begin
          flags_d = NZCV;
        end
        state_d = is_compare ? StIdle : StWb;
      end
      StWb: begin
        if (wb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cmd_q         <= CmdMov;
      src1_q        <= '0;
      src2_q        <= '0;
      shift_carry_q <= 1'b0;
      was_shifted_q <= 1'b0;
      set_flags_q   <= 1'b0;
      rd_q          <= '0;
      flags_q       <= '0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      cmd_err_q     <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      shift_carry_q <= shift_carry_d;
      was_shifted_q <= was_shifted_d;
      set_flags_q   <= set_flags_d;
      rd_q          <= rd_d;
      flags_q       <= flags_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      cmd_err_q     <= cmd_err_d;
      op_count_q    <= op_count_d;
    end
  end

  assign req_ready       = (state_q == StIdle) && !reset;
  assign wb_valid        = (state_q == StWb);
  assign CTRL_cmd        = cmd_q;
  assign src1            = src1_q;
  assign src2            = src2_q;
  assign src2shift_carry = shift_carry_q;
  assign was_shifted     = was_shifted_q;
  assign flags           = flags_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign cmd_err         = cmd_err_q;
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural registered ALU, a directed vector table,
// hand-written corner sequences and randomized operations against a transaction-level model.
module tb_alu_issue_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_cmd;
  logic [31:0] req_src1, req_src2;
  logic        req_shift_carry, req_was_shifted, req_set_flags;
  logic [3:0]  req_rd;
  logic [4:0]  CTRL_cmd;
  logic [31:0] src1, src2;
  logic        src2shift_carry, was_shifted;
  logic [3:0]  flags;
  logic [31:0] ALU_output;
  logic [3:0]  NZCV;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        cmd_err;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_flags;
  logic [15:0] m_count;
  logic [4:0]  m_cmd;
  logic [31:0] m_a;

  alu_issue_ctrl dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_cmd         (req_cmd),
    .req_src1        (req_src1),
    .req_src2        (req_src2),
    .req_shift_carry (req_shift_carry),
    .req_was_shifted (req_was_shifted),
    .req_set_flags   (req_set_flags),
    .req_rd          (req_rd),
    .CTRL_cmd        (CTRL_cmd),
    .src1            (src1),
    .src2            (src2),
    .src2shift_carry (src2shift_carry),
    .was_shifted     (was_shifted),
    .flags           (flags),
    .ALU_output      (ALU_output),
    .NZCV            (NZCV),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .cmd_err         (cmd_err),
    .op_count        (op_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // ARM-style data-processing result: returns {N,Z,C,V,result}.
  function automatic logic [35:0] alu_ref(input logic [4:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic sc,
                                          input logic cin, input logic vin);
    logic [32:0] sum;
    logic [31:0] x, y, r;
    logic        c, v, ci, arith;
    arith = 1'b1; x = a; y = b; ci = 1'b0; r = '0; c = sc; v = vin;
    case (cmd)
      5'd2, 5'd10: begin y = ~b; ci = 1'b1; end
      5'd3:        begin x = b; y = ~a; ci = 1'b1; end
      5'd4, 5'd11: ci = 1'b0;
      5'd5:        ci = cin;
      5'd6:        begin y = ~b; ci = cin; end
      5'd7:        begin x = b; y = ~a; ci = cin; end
      default:     arith = 1'b0;
    endcase
    if (arith) begin
      sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      r   = sum[31:0];
      c   = sum[32];
      v   = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      case (cmd)
        5'd0, 5'd8:  r = a & b;
        5'd1, 5'd9:  r = a ^ b;
        5'd12:       r = a | b;
        5'd13:       r = b;
        5'd14:       r = a & ~b;
        5'd15:       r = ~b;
        default:     r = a * b;
      endcase
    end
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // External ALU: registers its result every cycle from the controller's outputs.
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) {NZCV, ALU_output} <= '0;
    else       {NZCV, ALU_output} <= alu_ref(CTRL_cmd, src1, src2, src2shift_carry,
                                             flags[1], flags[0]);
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_cmp(input logic [4:0] c);
    return (c >= 5'd8) && (c <= 5'd11);
  endfunction

  task automatic do_op(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic ws, input logic sf, input logic [3:0] rd,
                       input int stall, input logic [31:0] exp_data,
                       input logic [3:0] exp_flags, input logic exp_wb);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_op", 32'(req_ready), 32'd1);
    req_cmd = cmd; req_src1 = a; req_src2 = b; req_shift_carry = sc;
    req_was_shifted = ws; req_set_flags = sf; req_rd = rd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    m_cmd = cmd; m_a = a;
    chk("issue_ready_low", 32'(req_ready), 32'd0);
    chk("issue_ctrl", 32'({CTRL_cmd, was_shifted, src2shift_carry}), 32'({cmd, ws, sc}));
    chk("issue_src1", src1, a);
    chk("issue_src2", src2, b);
    chk("issue_flags_hold", 32'(flags), 32'(m_flags));
    tick();
    chk("capture_flags_hold", 32'(flags), 32'(m_flags));
    chk("capture_wb_low", 32'(wb_valid), 32'd0);
    tick();
    m_count++;
    m_flags = exp_flags;
    chk("post_flags", 32'(flags), 32'(m_flags));
    chk("post_op_count", 32'(op_count), 32'(m_count));
    if (exp_wb) begin
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_data", wb_data, exp_data);
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      for (int i = 0; i < stall; i++) begin
        // Requests arriving during writeback must be ignored, legal or not.
        req_valid = 1'b1;
        req_cmd   = (i % 2 == 1) ? 5'h1F : 5'd4;
        req_src1  = ~a;
        tick();
        chk("stall_wb_valid", 32'(wb_valid), 32'd1);
        chk("stall_wb_data", wb_data, exp_data);
        chk("stall_wb_rd", 32'(wb_rd), 32'(rd));
        chk("stall_ready_low", 32'(req_ready), 32'd0);
        chk("stall_no_cmd_err", 32'(cmd_err), 32'd0);
        chk("stall_ctrl_hold", 32'(CTRL_cmd), 32'(m_cmd));
        chk("stall_src1_hold", src1, m_a);
      end
      req_valid = 1'b0;
      wb_ready  = 1'b1;
      tick();
      wb_ready  = 1'b0;
      chk("wb_done_low", 32'(wb_valid), 32'd0);
      chk("wb_done_no_cmd_err", 32'(cmd_err), 32'd0);
    end else begin
      chk("cmp_no_wb", 32'(wb_valid), 32'd0);
    end
    chk("op_done_ready", 32'(req_ready), 32'd1);
    chk("idle_ctrl_hold", 32'(CTRL_cmd), 32'(m_cmd));
  endtask

  task automatic illegal(input logic [4:0] c);
    req_valid = 1'b1; req_cmd = c; req_src1 = $urandom; req_src2 = $urandom;
    chk("illegal_pre_err", 32'(cmd_err), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("illegal_err_pulse", 32'(cmd_err), 32'd1);
    chk("illegal_ready", 32'(req_ready), 32'd1);
    chk("illegal_ctrl_hold", 32'(CTRL_cmd), 32'(m_cmd));
    chk("illegal_src1_hold", src1, m_a);
    chk("illegal_flags_hold", 32'(flags), 32'(m_flags));
    chk("illegal_count_hold", 32'(op_count), 32'(m_count));
    tick();
    chk("illegal_err_end", 32'(cmd_err), 32'd0);
  endtask

  typedef struct {
    logic [4:0]  cmd;
    logic [31:0] a, b;
    logic        sc, ws, sf;
    logic [3:0]  rd;
    int          stall;
    logic [31:0] data;
    logic [3:0]  fl;
    logic        wb;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] r;
    logic [31:0] opa, opb, pick[5];
    logic [4:0]  c;
    logic        sf;
    logic [3:0]  ef;

    // cmd, a, b, sc, ws, sf, rd, stall, data, flags, wb  (flags chain from reset)
    tbl[0]  = '{5'd4,  32'd5,          32'd7,          1'b0, 1'b0, 1'b1, 4'd3,  0, 32'd12,
                4'b0000, 1'b1};
    tbl[1]  = '{5'd2,  32'd3,          32'd3,          1'b0, 1'b0, 1'b1, 4'd4,  3, 32'd0,
                4'b0110, 1'b1};
    tbl[2]  = '{5'd5,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0, 4'd5,  1, 32'd3,
                4'b0110, 1'b1};
    tbl[3]  = '{5'd10, 32'h8000_0000,  32'd1,          1'b0, 1'b0, 1'b0, 4'd6,  0, 32'd0,
                4'b0011, 1'b0};
    tbl[4]  = '{5'd13, 32'd9,          32'd0,          1'b0, 1'b0, 1'b1, 4'd1,  0, 32'd0,
                4'b0101, 1'b1};
    tbl[5]  = '{5'd12, 32'h0000_00F0,  32'h0000_000F,  1'b1, 1'b1, 1'b0, 4'd2,  2, 32'hFF,
                4'b0101, 1'b1};
    tbl[6]  = '{5'd11, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 1'b0, 4'd7,  0, 32'd0,
                4'b0110, 1'b0};
    tbl[7]  = '{5'd6,  32'd5,          32'd2,          1'b0, 1'b0, 1'b1, 4'd8,  0, 32'd3,
                4'b0010, 1'b1};
    tbl[8]  = '{5'd7,  32'd2,          32'd5,          1'b0, 1'b0, 1'b1, 4'd9,  0, 32'd3,
                4'b0010, 1'b1};
    tbl[9]  = '{5'd16, 32'd6,          32'd7,          1'b1, 1'b0, 1'b1, 4'd10, 0, 32'd42,
                4'b0010, 1'b1};
    tbl[10] = '{5'd8,  32'h8000_0000,  32'h8000_0001,  1'b0, 1'b0, 1'b0, 4'd11, 0, 32'd0,
                4'b1000, 1'b0};
    tbl[11] = '{5'd3,  32'd1,          32'd0,          1'b0, 1'b0, 1'b1, 4'd15, 0,
                32'hFFFF_FFFF, 4'b1000, 1'b1};

    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_src1 = '0; req_src2 = '0;
    req_shift_carry = 1'b0; req_was_shifted = 1'b0; req_set_flags = 1'b0; req_rd = '0;
    wb_ready = 1'b0;
    m_flags = '0; m_count = '0; m_cmd = 5'd13; m_a = '0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ctrl", 32'({CTRL_cmd, was_shifted, src2shift_carry}), 32'({5'd13, 2'b00}));
    chk("rst_src1", src1, 32'd0);
    chk("rst_src2", src2, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_wb", 32'({wb_valid, wb_rd, cmd_err}), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].sc, tbl[i].ws, tbl[i].sf, tbl[i].rd,
            tbl[i].stall, tbl[i].data, tbl[i].fl, tbl[i].wb);
    end

    illegal(5'b10101);
    illegal(5'b10001);

    // Reset landing in CAPTURE must discard the operation entirely.
    req_cmd = 5'd2; req_src1 = 32'd3; req_src2 = 32'd3; req_set_flags = 1'b1;
    req_rd = 4'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_cap_flags", 32'(flags), 32'd0);
    chk("rst_cap_wb", 32'(wb_valid), 32'd0);
    chk("rst_cap_count", 32'(op_count), 32'd0);
    chk("rst_cap_ready", 32'(req_ready), 32'd0);
    chk("rst_cap_ctrl", 32'(CTRL_cmd), 32'd13);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_cap_ready_after", 32'(req_ready), 32'd1);
    m_flags = '0; m_count = '0; m_cmd = 5'd13; m_a = '0;
    tick();
    chk("rst_cap_no_ghost_count", 32'(op_count), 32'd0);
    chk("rst_cap_no_ghost_wb", 32'(wb_valid), 32'd0);
    chk("rst_cap_no_ghost_flags", 32'(flags), 32'd0);

    // Preload as if 65535 operations had completed; the next one wraps the counter.
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    m_count = 16'hFFFF;
    do_op(5'd10, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 4'd0, 0, 32'd0, 4'b0110, 1'b0);

    pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
    pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) illegal(5'(17 + $urandom_range(0, 14)));
      c   = 5'($urandom_range(0, 16));
      opa = ($urandom_range(0, 1) == 1) ? $urandom : pick[$urandom_range(0, 4)];
      opb = ($urandom_range(0, 1) == 1) ? $urandom : pick[$urandom_range(0, 4)];
      sf  = 1'($urandom_range(0, 1));
      req_shift_carry = 1'($urandom_range(0, 1));
      r   = alu_ref(c, opa, opb, req_shift_carry, m_flags[1], m_flags[0]);
      ef  = (sf || is_cmp(c)) ? r[35:32] : m_flags;
      do_op(c, opa, opb, req_shift_carry, 1'($urandom_range(0, 1)), sf,
            4'($urandom_range(0, 15)), $urandom_range(0, 3), r[31:0], ef, !is_cmp(c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; all state SHALL clear immediately when reset is asserted.
REQ-002 SHALL have ports:
  - CLOCK_50  in  1  system clock, rising edge.
  - reset  in  1  asynchronous, active-high.
  - req_valid  in  1  operation request.
  - req_ready  out  1  controller can accept a request.
  - req_cmd  in  5  ALU command code.
  - req_src1, req_src2  in  32  operands.
  - req_shift_carry  in  1  carry out of the operand shifter.
  - req_was_shifted  in  1  operand 2 was shifted.
  - req_set_flags  in  1  S bit.
  - req_rd  in  4  destination register.
  - CTRL_cmd  out  5  to the ALU.
  - src1, src2  out  32  to the ALU.
  - src2shift_carry  out  1  to the ALU.
  - was_shifted  out  1  to the ALU.
  - flags  out  4  flag register {N,Z,C,V} to the ALU; also the architectural flags.
  - ALU_output  in  32  ALU result, registered inside the ALU.
  - NZCV  in  4  flags computed by the ALU.
  - wb_valid  out  1  writeback available.
  - wb_ready  in  1  writeback accepted.
  - wb_rd  out  4  writeback destination register.
  - wb_data  out  32  writeback data.
  - cmd_err  out  1  one-cycle pulse flagging an illegal command.
  - op_count  out  16  count of completed operations.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, ISSUE, CAPTURE, WB.
REQ-004 req_ready SHALL be 1 only in IDLE with reset deasserted.
REQ-005 SHALL accept a request on a rising edge in IDLE when req_valid=1 and req_cmd<=5'b10000.
  - Accept latches cmd, src1, src2, shift_carry, was_shifted, set_flags and rd into the ALU-facing registers.
  - State then goes to ISSUE.
REQ-006 When req_valid=1 in IDLE with req_cmd>=5'b10001, SHALL:
  - pulse cmd_err high for exactly one cycle, on the following cycle;
  - leave the state, the ALU-facing outputs and the flags unchanged.
REQ-007 ISSUE SHALL last one cycle; the ALU samples the operands at the end of ISSUE, and the state then goes to CAPTURE.
REQ-008 In CAPTURE (one cycle), at the closing edge the controller SHALL:
  - register ALU_output into wb_data and rd into wb_rd;
  - update flags when set_flags=1 or cmd is in 5'b01000..5'b01011; otherwise flags hold;
  - increment op_count.
REQ-009 Leaving CAPTURE:
  - cmd in 5'b01000..5'b01011 (TST, TEQ, CMP, CMN) SHALL return to IDLE with no writeback;
  - all other commands SHALL go to WB.
REQ-010 wb_valid SHALL be 1 exactly while in WB, and wb_rd/wb_data SHALL stay stable until wb_ready=1.
REQ-011 WB SHALL go to IDLE on the edge where wb_ready=1.
REQ-012 Latency: accept at edge T, ALU samples at T+1, wb_valid rises after T+2; minimum issue interval is 3 cycles for compare/test and 4 cycles for writeback commands.
REQ-013 CTRL_cmd, src1, src2, src2shift_carry and was_shifted SHALL stay constant from the accept edge until the next accept; in IDLE they hold the last operation.
REQ-014 flags SHALL change only at a CAPTURE edge; during ISSUE/CAPTURE they present the pre-operation value, so ADC/SBC/RSC see the old C.
REQ-015 op_count SHALL wrap from 16'hFFFF to 16'h0000 with no side effect.
REQ-016 A request presented outside IDLE SHALL be ignored and SHALL NOT raise cmd_err.

Reset
REQ-017 While reset=1, SHALL hold:
  - state=IDLE, req_ready=0;
  - CTRL_cmd=5'b01101 (MOV), src1=0, src2=0, src2shift_carry=0, was_shifted=0;
  - flags=4'b0000;
  - wb_valid=0, wb_rd=0, wb_data=0;
  - cmd_err=0, op_count=0.
REQ-018 Reset asserted mid-operation SHALL abort the operation: no flag update, no op_count increment, no writeback.
REQ-019 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-020 ADD: cmd=5'b00100, src1=5, src2=7, set_flags=1, rd=3, wb_ready=1 -> wb_valid rises after edge T+2, wb_data=12, wb_rd=3, flags=4'b0000, op_count=1.
REQ-021 SUB: cmd=5'b00010, src1=3, src2=3, set_flags=1 -> wb_data=0, flags=4'b0110; a following ADC 1+1 -> wb_data=3.
REQ-022 CMP: cmd=5'b01010, src1=32'h80000000, src2=1, set_flags=0 -> flags=4'b0011, wb_valid never asserts, req_ready=1 three cycles after accept.
REQ-023 Backpressure: wb_ready held 0 for 3 cycles in WB -> wb_valid/wb_data stable, req_ready=0 throughout, and a new req_valid is ignored.
REQ-024 Illegal command: req_cmd=5'b10101 in IDLE -> cmd_err high for one cycle, ALU outputs, flags and op_count unchanged, req_ready stays 1.
REQ-025 Reset in CAPTURE and wrap-around:
  - reset asserted in CAPTURE -> flags=0, wb_valid=0, op_count=0 immediately;
  - op_count preloaded by 65535 operations -> next op_count=0.
